// File: rtl/accel_spi_reader.sv
// SPI mode-3 master for the ADXL345: writes DATA_FORMAT and POWER_CTL once after reset,
// then reads DATAX0/DATAX1 every SAMPLE_PERIOD clocks and presents {DATAX1,DATAX0}.
module accel_spi_reader #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 50000,
  parameter logic [7:0]  FORMAT_VAL    = 8'h01,
  parameter logic [7:0]  POWER_VAL     = 8'h08
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic [15:0] accel_x,
  output logic        sample_valid,
  output logic        init_done
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned PH_W    = 6;
  localparam int unsigned FRAME_W = 24;
  localparam int unsigned WR_BITS = 16;
  localparam int unsigned RD_BITS = 24;
  localparam int unsigned PER_W   = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;

  // Frames are left-aligned in the shift register; writes use only the top 16 bits.
  localparam logic [FRAME_W-1:0] FMT_FRAME = {2'b00, 6'h31, FORMAT_VAL, 8'h00};
  localparam logic [FRAME_W-1:0] PWR_FRAME = {2'b00, 6'h2D, POWER_VAL, 8'h00};
  localparam logic [FRAME_W-1:0] RD_FRAME  = {2'b11, 6'h32, 16'h0000};

  typedef enum logic [2:0] {
    ST_START,
    ST_WR_FMT,
    ST_GAP1,
    ST_WR_PWR,
    ST_IDLE,
    ST_READ
  } state_t;

  state_t               state_q;
  logic [DIV_W-1:0]     div_q;
  logic [PH_W-1:0]      phase_q;
  logic [PH_W-1:0]      last_phase_q;
  logic                 busy_q;
  logic [FRAME_W-1:0]   shift_q;
  logic [15:0]          rx_q;
  logic [PER_W-1:0]     period_q;
  logic                 cs_n_q;
  logic                 sclk_q;
  logic                 mosi_q;
  logic [15:0]          accel_x_q;
  logic                 sample_valid_q;
  logic                 init_done_q;

  logic                 div_end_c;
  logic                 done_c;
  logic                 tick_c;
  logic                 start_c;
  logic [FRAME_W-1:0]   frame_c;
  logic [PH_W-1:0]      last_c;

  assign div_end_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign done_c    = busy_q && div_end_c && (phase_q == last_phase_q);
  assign tick_c    = init_done_q && (period_q == '0);

  // Frame launch selection: which frame starts this cycle, and its last half-phase index.
  always_comb begin
    start_c = 1'b0;
    frame_c = RD_FRAME;
    last_c  = PH_W'(2 * RD_BITS);
    case (state_q)
      ST_START: begin
        start_c = 1'b1;
        frame_c = FMT_FRAME;
        last_c  = PH_W'(2 * WR_BITS);
      end
      ST_GAP1: begin
        start_c = div_end_c;
        frame_c = PWR_FRAME;
        last_c  = PH_W'(2 * WR_BITS);
      end
      ST_IDLE: begin
        start_c = tick_c;
      end
      default: begin
        start_c = 1'b0;
      end
    endcase
  end

  // Sequencer, transfer engine and output registers.
  // Half-phase 0 is the CS setup; odd half-phases hold SCLK low, even ones hold it high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_START;
      div_q          <= '0;
      phase_q        <= '0;
      last_phase_q   <= '0;
      busy_q         <= 1'b0;
      shift_q        <= '0;
      rx_q           <= '0;
      period_q       <= '0;
      cs_n_q         <= 1'b1;
      sclk_q         <= 1'b1;
      mosi_q         <= 1'b0;
      accel_x_q      <= '0;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;

      if (init_done_q) begin
        period_q <= (period_q == PER_W'(SAMPLE_PERIOD - 1)) ? '0 : period_q + PER_W'(1);
      end

      if (start_c) begin
        cs_n_q       <= 1'b0;
        sclk_q       <= 1'b1;
        mosi_q       <= frame_c[FRAME_W-1];
        shift_q      <= frame_c;
        div_q        <= '0;
        phase_q      <= '0;
        last_phase_q <= last_c;
        busy_q       <= 1'b1;
      end else if (busy_q) begin
        if (div_end_c) begin
          div_q <= '0;
          if (phase_q == last_phase_q) begin
            cs_n_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            phase_q <= phase_q + PH_W'(1);
            if (!phase_q[0]) begin
              sclk_q <= 1'b0;
              // The first falling edge keeps the MSB already on MOSI.
              if (phase_q != '0) begin
                shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
                mosi_q  <= shift_q[FRAME_W-2];
              end
            end else begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[14:0], spi_miso};
            end
          end
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end else begin
        div_q <= div_end_c ? '0 : div_q + DIV_W'(1);
      end

      case (state_q)
        ST_START: begin
          state_q <= ST_WR_FMT;
        end
        ST_WR_FMT: begin
          if (done_c) state_q <= ST_GAP1;
        end
        ST_GAP1: begin
          if (div_end_c) state_q <= ST_WR_PWR;
        end
        ST_WR_PWR: begin
          if (done_c) begin
            state_q     <= ST_IDLE;
            init_done_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (tick_c) state_q <= ST_READ;
        end
        ST_READ: begin
          // READ keeps CS high for CLK_DIV cycles after the frame; ticks in that window are dropped.
          if (done_c) begin
            accel_x_q      <= {rx_q[7:0], rx_q[15:8]};
            sample_valid_q <= 1'b1;
          end else if (!busy_q && div_end_c) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_START;
        end
      endcase
    end
  end

  assign spi_cs_n     = cs_n_q;
  assign spi_sclk     = sclk_q;
  assign spi_mosi     = mosi_q;
  assign accel_x      = accel_x_q;
  assign sample_valid = sample_valid_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: two instances (SAMPLE_PERIOD 200 and an undersized 100), each
// driven by an ADXL345 slave model that decodes frames and predicts accel_x from the bytes it returns.
module tb_accel_spi_reader;

  localparam int unsigned CD = 2;
  localparam int unsigned NT = 12;

  typedef struct {
    logic [7:0]  x0;
    logic [7:0]  x1;
    logic [15:0] exp_x;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        miso [2];
  logic        cs_n [2];
  logic        sclk [2];
  logic        mosi [2];
  logic [15:0] ax [2];
  logic        sv [2];
  logic        idn [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  vec_t tbl [NT];

  accel_spi_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(200)) dut_a (
    .clk(clk), .reset(reset), .spi_miso(miso[0]), .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]),
    .spi_mosi(mosi[0]), .accel_x(ax[0]), .sample_valid(sv[0]), .init_done(idn[0])
  );

  accel_spi_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(100)) dut_b (
    .clk(clk), .reset(reset), .spi_miso(miso[1]), .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]),
    .spi_mosi(mosi[1]), .accel_x(ax[1]), .sample_valid(sv[1]), .init_done(idn[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the sample is the two received data bytes, high byte second.
  function automatic logic [15:0] model_x(input logic [7:0] x0, input logic [7:0] x1);
    return {x1, x0};
  endfunction

  // Expected MOSI contents of the n-th frame after reset.
  function automatic logic [23:0] exp_frame(input int n);
    if (n == 0) return 24'h003101;
    if (n == 1) return 24'h002D08;
    return 24'hF20000;
  endfunction

  // Slave/monitor state, one slot per instance.
  logic        p_cs [2];
  logic        p_sclk [2];
  logic        p_idn [2];
  int          t_fall [2];
  int          t_rise [2];
  int          t_init [2];
  int          last_rd [2];
  int          nfr [2];
  int          nbits [2];
  int          nfalls [2];
  int          nreads [2] = '{0, 0};
  int          nvalid [2] = '{0, 0};
  int          ridx [2] = '{0, 0};
  logic [23:0] mo [2];
  logic [23:0] resp [2];
  logic [15:0] exp_ax [2];
  bit          rd [2];
  vec_t        cur_v;
  logic [7:0]  rx0;
  logic [7:0]  rx1;
  int          nb;
  bit          ended;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        p_cs[i] = 1'b1; p_sclk[i] = 1'b1; p_idn[i] = 1'b0;
        nfr[i] = 0; t_init[i] = -1; last_rd[i] = -1; t_rise[i] = 0; miso[i] = 1'b0;
      end else begin
        ended = 1'b0;
        if (idn[i] && !p_idn[i]) t_init[i] = cyc;
        if (p_cs[i] && !cs_n[i]) begin
          t_fall[i] = cyc; nbits[i] = 0; nfalls[i] = 0; mo[i] = '0;
          rd[i] = (nfr[i] >= 2);
          if (nfr[i] == 1) check("init_gap_ge_div", 32'(cyc - t_rise[i] >= int'(CD)), 32'd1);
          if (rd[i]) begin
            if (i == 0) begin
              cur_v = tbl[ridx[0] % NT];
              ridx[0]++;
              rx0 = cur_v.x0; rx1 = cur_v.x1;
              exp_ax[0] = cur_v.exp_x;
            end else begin
              rx0 = 8'($urandom); rx1 = 8'($urandom);
              exp_ax[1] = model_x(rx0, rx1);
            end
            resp[i] = {8'($urandom), rx0, rx1};
            if (last_rd[i] < 0) check("first_read_after_init", 32'(cyc - t_init[i]), 32'd1);
            else check("read_spacing", 32'(cyc - last_rd[i]), 32'd200);
            last_rd[i] = cyc;
          end else begin
            resp[i] = 24'($urandom);
          end
        end
        if (!cs_n[i]) begin
          if (p_sclk[i] && !sclk[i] && nfalls[i] < 24) begin
            miso[i] = resp[i][5'(23 - nfalls[i])];
            nfalls[i]++;
          end
          if (!p_sclk[i] && sclk[i]) begin
            mo[i] = {mo[i][22:0], mosi[i]};
            nbits[i]++;
          end
        end
        if (!p_cs[i] && cs_n[i]) begin
          ended = 1'b1;
          nb = rd[i] ? 24 : 16;
          check("cs_low_len", 32'(cyc - t_fall[i]), 32'((2 * nb + 1) * int'(CD)));
          check("sclk_bits", 32'(nbits[i]), 32'(nb));
          check("mosi_frame", 32'(mo[i]), 32'(exp_frame(nfr[i])));
          if (rd[i]) begin
            check("valid_at_cs_rise", 32'(sv[i]), 32'd1);
            check("accel_x_at_cs_rise", 32'(ax[i]), 32'(exp_ax[i]));
            nreads[i]++;
          end
          if (nfr[i] == 1) check("init_done_edge", 32'({p_idn[i], idn[i]}), 32'd1);
          t_rise[i] = cyc;
          nfr[i]++;
        end
        if (sv[i]) begin
          nvalid[i]++;
          if (!(ended && rd[i])) check("stray_valid", 32'(sv[i]), 32'd0);
        end
        p_cs[i] = cs_n[i]; p_sclk[i] = sclk[i]; p_idn[i] = idn[i];
      end
    end
  end

  task automatic wait_reads(input int i, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(posedge clk);
      #1;
      if (nreads[i] >= n) ok = 1'b1;
    end
    if (!ok) check("timeout_reads", 32'(nreads[i]), 32'(n));
  endtask

  bit ok;
  int base;

  initial begin
    tbl[0] = '{8'h34, 8'hF2, 16'hF234};
    tbl[1] = '{8'h00, 8'h80, 16'h8000};
    tbl[2] = '{8'hFF, 8'h7F, 16'h7FFF};
    for (int r = 3; r < int'(NT); r++) begin
      tbl[r].x0 = 8'($urandom);
      tbl[r].x1 = 8'($urandom);
      tbl[r].exp_x = model_x(tbl[r].x0, tbl[r].x1);
    end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      check("rst_cs_n", 32'(cs_n[i]), 32'd1);
      check("rst_sclk", 32'(sclk[i]), 32'd1);
      check("rst_mosi", 32'(mosi[i]), 32'd0);
      check("rst_accel_x", 32'(ax[i]), 32'd0);
      check("rst_valid", 32'(sv[i]), 32'd0);
      check("rst_init_done", 32'(idn[i]), 32'd0);
    end
    reset = 1'b0;

    // Table vectors: one read per row, accel_x must hold the row's value afterwards.
    for (int r = 0; r < 8; r++) begin
      wait_reads(0, r + 1, 600, ok);
      if (ok) check("tbl_accel_x", 32'(ax[0]), 32'(tbl[r].exp_x));
    end
    check("b_reads_seen", 32'(nreads[1] >= 5), 32'd1);
    check("a_pulse_count", 32'(nvalid[0]), 32'(nreads[0]));
    check("b_pulse_count", 32'(nvalid[1]), 32'(nreads[1]));

    // Reset 40 cycles into a read frame.
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (!cs_n[0] && nfr[0] >= 2 && (cyc - t_fall[0]) == 40) ok = 1'b1;
    end
    if (!ok) check("timeout_mid_read", 32'(cs_n[0]), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_cs_n", 32'(cs_n[0]), 32'd1);
    check("async_sclk", 32'(sclk[0]), 32'd1);
    check("async_mosi", 32'(mosi[0]), 32'd0);
    check("async_accel_x", 32'(ax[0]), 32'd0);
    check("async_init_done", 32'(idn[0]), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    base = nreads[0];
    wait_reads(0, base + 2, 800, ok);
    if (ok) begin
      check("frames_after_reset", 32'(nfr[0]), 32'd4);
      check("accel_x_after_reset", 32'(ax[0]), 32'(tbl[(ridx[0] - 1) % NT].exp_x));
    end
    check("a_pulse_count_end", 32'(nvalid[0]), 32'(nreads[0]));
    check("b_pulse_count_end", 32'(nvalid[1]), 32'(nreads[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
